rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Round-robin arbiter that produces a binary grant index and a grant-valid strobe.
- Sits directly upstream of the enable-gated N-to-2^N decoder: GNT_IDX drives the decoder's encoded input and GNT_VLD drives its enable, so the decoder output is the one-hot grant bus.
- Holds a grant until the owner signals completion, drops its request, or exceeds a hold limit.

Parameters:
- EncodeWidth, 4, width of the grant index.
- ReqWidth, 2**EncodeWidth, number of requesters.
- MaxHold, 64, maximum cycles a grant may be held before forced release; 0 disables the limit.
- HoldCntWidth, $clog2(MaxHold+1), width of the hold counter; minimum 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- REQ  input  ReqWidth  request vector; bit i = requester i wants the resource.
- DONE  input  1  current grant owner finished; sampled only in GRANT.
- GNT_IDX  output  EncodeWidth  index of the granted requester; registered.
- GNT_VLD  output  1  grant valid; registered; drives the downstream decoder enable.
- TIMEOUT  output  1  one-cycle pulse when a grant is force-released by MaxHold.

Behaviour:
- Reset: RST_N=0 sampled at a rising edge sets state=IDLE, GNT_IDX=0, GNT_VLD=0, TIMEOUT=0, priority pointer PTR=0, hold counter=0. Reset mid-grant drops GNT_VLD on that same edge. No partial state survives.
- States: IDLE and GRANT. GNT_VLD=1 exactly when state=GRANT.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first set bit scanning PTR, PTR+1, …, ReqWidth-1, 0, …, PTR-1 (modulo ReqWidth).
  - Next edge: GNT_IDX=selected, GNT_VLD=1, hold counter=0, state=GRANT.
  - Latency: REQ asserted before edge t gives GNT_VLD=1 after edge t.
- GRANT: GNT_IDX is stable for the whole grant. Release occurs at the next edge if any of these holds:
  - (a) DONE=1;
  - (b) REQ[GNT_IDX]=0, an implicit release;
  - (c) MaxHold≠0 and hold counter==MaxHold-1, a forced release.
- Without release, the hold counter increments (saturating) and the state stays GRANT.
- On release at an edge:
  - state=IDLE, GNT_VLD=0, PTR=(GNT_IDX+1) mod ReqWidth (natural wrap at 2^EncodeWidth), hold counter=0.
  - GNT_IDX keeps its last value. It is don't-care downstream because the enable is low.
- TIMEOUT=1 for exactly one cycle, registered with the release edge, only when (c) is the sole cause. If DONE or the implicit release coincides with the limit, TIMEOUT stays 0.
- Bubble: there is always at least one IDLE cycle between consecutive grants, so GNT_VLD shows one low cycle. Back-to-back grants to the same requester are therefore impossible while other requesters are pending. Fairness: PTR advance guarantees each requester a grant within ReqWidth grant periods.
- A single requester that stays asserted is re-granted after the one-cycle bubble.
- DONE in IDLE is ignored. REQ changes in GRANT on non-owner bits are ignored.
- MaxHold=1: every grant lasts exactly one cycle; TIMEOUT pulses unless DONE or implicit release coincides.
- Outputs are glitch-free registers. There is no combinational path from REQ or DONE to any output.

Test Plan:
- Reset/idle: hold RST_N=0 for 2 edges with REQ=16'hFFFF → GNT_VLD=0, GNT_IDX=0, TIMEOUT=0. Release reset, REQ=0 for 5 cycles → GNT_VLD remains 0.
- Single grant: REQ=16'h0020 at edge t → GNT_IDX=5, GNT_VLD=1 after t. Pulse DONE at t+3 → GNT_VLD=0 after t+3, PTR=6.
- Rotation and wrap: REQ=16'h8003, each grant closed by a 1-cycle DONE → grant order 0,1,15,0,1. GNT_VLD shows one low cycle between grants. The 15→0 wrap is correct.
- Implicit release: grant index 3 active, then REQ[3] drops with DONE=0 → GNT_VLD=0 at the next edge, TIMEOUT=0, next pending requester >3 granted after the bubble.
- Timeout: MaxHold=4, REQ=16'h0001 held, DONE=0 → GNT_VLD high exactly 4 cycles, TIMEOUT pulses once with the release, re-grant of index 0 after the 1-cycle bubble. Repeat with DONE=1 on the 4th cycle → TIMEOUT stays 0.
- Reset mid-grant: grant index 9 active, RST_N=0 for one edge → GNT_VLD=0, GNT_IDX=0, PTR=0 after that edge. With REQ=16'h0201 afterwards → index 0 granted first.

Source files
------------

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter emitting a registered binary grant index plus grant-valid,
// intended to feed an enable-gated N-to-2^N decoder that forms the one-hot grant bus.
module rr_grant_encoder #(
  parameter int EncodeWidth  = 4,
  parameter int ReqWidth     = 2**EncodeWidth,
  parameter int MaxHold      = 64,
  parameter int HoldCntWidth = (MaxHold < 1) ? 1 : $clog2(MaxHold + 1)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [ReqWidth-1:0]    REQ,
  input  logic                   DONE,
  output logic [EncodeWidth-1:0] GNT_IDX,
  output logic                   GNT_VLD,
  output logic                   TIMEOUT
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [HoldCntWidth-1:0] HOLD_LAST =
    (MaxHold > 0) ? HoldCntWidth'(MaxHold - 1) : '0;
  localparam logic [HoldCntWidth-1:0] HOLD_SAT = '1;

  state_t                  r_state, w_state_nxt;
  logic [EncodeWidth-1:0]  r_idx, w_idx_nxt;
  logic [EncodeWidth-1:0]  r_ptr, w_ptr_nxt;
  logic [HoldCntWidth-1:0] r_hold, w_hold_nxt;
  logic                    r_vld, w_vld_nxt;
  logic                    r_timeout, w_timeout_nxt;

  logic                    w_any;
  logic [EncodeWidth-1:0]  w_sel;
  logic                    w_owner_req;
  logic                    w_limit;
  logic                    w_release;

  // (a + b) mod ReqWidth for a, b < ReqWidth; one extra bit absorbs the carry.
  function automatic logic [EncodeWidth-1:0] wrap_add(
    input logic [EncodeWidth-1:0] a,
    input int                     b
  );
    logic [EncodeWidth:0] s;
    s = {1'b0, a} + (EncodeWidth+1)'(b);
    if (s >= (EncodeWidth+1)'(ReqWidth)) s = s - (EncodeWidth+1)'(ReqWidth);
    return s[EncodeWidth-1:0];
  endfunction

  // Scan from the far end back toward PTR so the closest set bit wins.
  always_comb begin
    w_any = |REQ;
    w_sel = r_ptr;
    for (int k = ReqWidth - 1; k >= 0; k--) begin
      if (REQ[wrap_add(r_ptr, k)]) w_sel = wrap_add(r_ptr, k);
    end
  end

  assign w_owner_req = REQ[r_idx];
  assign w_limit     = (MaxHold != 0) && (r_hold == HOLD_LAST);
  assign w_release   = DONE || !w_owner_req || w_limit;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_sel;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt   = S_IDLE;
          w_ptr_nxt     = wrap_add(r_idx, 1);
          w_hold_nxt    = '0;
          // Only flag a timeout when the limit alone forced the release.
          w_timeout_nxt = w_limit && !DONE && w_owner_req;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_vld_nxt = (w_state_nxt == S_GRANT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_vld     <= w_vld_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign GNT_IDX = r_idx;
  assign GNT_VLD = r_vld;
  assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: a default instance plus a MaxHold=4 instance
// for the forced-release scenarios.
module tb_rr_grant_encoder;

  logic        CLK;
  logic        RST_N;
  logic [15:0] REQ, REQ4;
  logic        DONE, DONE4;
  logic [3:0]  GNT_IDX, GNT_IDX4;
  logic        GNT_VLD, GNT_VLD4;
  logic        TIMEOUT, TIMEOUT4;

  int total = 0;
  int bad   = 0;

  rr_grant_encoder dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DONE(DONE),
    .GNT_IDX(GNT_IDX), .GNT_VLD(GNT_VLD), .TIMEOUT(TIMEOUT)
  );

  rr_grant_encoder #(.MaxHold(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ4), .DONE(DONE4),
    .GNT_IDX(GNT_IDX4), .GNT_VLD(GNT_VLD4), .TIMEOUT(TIMEOUT4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ = 16'hFFFF; DONE = 1'b0; REQ4 = '0; DONE4 = 1'b0;
    tick(); tick();
    total++;
    if ({GNT_VLD, GNT_IDX, TIMEOUT} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got vld=%0b idx=%0d to=%0b want 0/0/0", GNT_VLD, GNT_IDX, TIMEOUT);
    end
    total++;
    if ({GNT_VLD4, GNT_IDX4, TIMEOUT4} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs4 got vld=%0b idx=%0d to=%0b want 0/0/0", GNT_VLD4, GNT_IDX4, TIMEOUT4);
    end
    RST_N = 1'b1; REQ = '0;
    for (int c = 0; c < 5; c++) begin
      DONE = (c == 2);  // DONE while idle must have no effect
      tick();
      total++;
      if (GNT_VLD !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_req cycle %0d got vld=%0b want 0", c, GNT_VLD);
      end
    end
    DONE = 1'b0;
  endtask

  task automatic test_single_grant();
    REQ = 16'h0020;
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL single_grant got vld=%0b idx=%0d want 1/5", GNT_VLD, GNT_IDX);
    end
    REQ = 16'h00A0;  // non-owner bit appears mid-grant
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL single_hold got vld=%0b idx=%0d want 1/5", GNT_VLD, GNT_IDX);
    end
    REQ = 16'h0020;
    tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    total++;
    if ({GNT_VLD, TIMEOUT} !== 2'b00) begin
      bad++;
      $display("FAIL single_release got vld=%0b to=%0b want 0/0", GNT_VLD, TIMEOUT);
    end
    REQ = 16'h0060;  // PTR=6 picks 6 over 5
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd6}) begin
      bad++;
      $display("FAIL ptr_after_release got vld=%0b idx=%0d want 1/6", GNT_VLD, GNT_IDX);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] order [5];
    order = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1};
    RST_N = 1'b0; REQ = '0;
    tick();
    RST_N = 1'b1; REQ = 16'h8003;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({GNT_VLD, GNT_IDX} !== {1'b1, order[i]}) begin
        bad++;
        $display("FAIL rotate_grant #%0d got vld=%0b idx=%0d want 1/%0d", i, GNT_VLD, GNT_IDX, order[i]);
      end
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      total++;
      if (GNT_VLD !== 1'b0) begin
        bad++;
        $display("FAIL rotate_bubble #%0d got vld=%0b want 0", i, GNT_VLD);
      end
    end
    REQ = '0;
  endtask

  task automatic test_implicit_release();
    REQ = 16'h0058;  // PTR=2: index 3 first
    tick();
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL implicit_grant got vld=%0b idx=%0d want 1/3", GNT_VLD, GNT_IDX);
    end
    REQ = 16'h0050;
    tick();
    total++;
    if ({GNT_VLD, TIMEOUT} !== 2'b00) begin
      bad++;
      $display("FAIL implicit_release got vld=%0b to=%0b want 0/0", GNT_VLD, TIMEOUT);
    end
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd4}) begin
      bad++;
      $display("FAIL implicit_next got vld=%0b idx=%0d want 1/4", GNT_VLD, GNT_IDX);
    end
    DONE = 1'b1; REQ = '0;
    tick();
    DONE = 1'b0;
  endtask

  task automatic test_timeout();
    REQ4 = 16'h0001;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++;
      if ({GNT_VLD4, GNT_IDX4, TIMEOUT4} !== {1'b1, 4'd0, 1'b0}) begin
        bad++;
        $display("FAIL timeout_hold cycle %0d got vld=%0b idx=%0d to=%0b want 1/0/0", c, GNT_VLD4, GNT_IDX4, TIMEOUT4);
      end
    end
    tick();
    total++;
    if ({GNT_VLD4, TIMEOUT4} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_release got vld=%0b to=%0b want 0/1", GNT_VLD4, TIMEOUT4);
    end
    tick();
    total++;
    if ({GNT_VLD4, GNT_IDX4, TIMEOUT4} !== {1'b1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL timeout_regrant got vld=%0b idx=%0d to=%0b want 1/0/0", GNT_VLD4, GNT_IDX4, TIMEOUT4);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      total++;
      if ({GNT_VLD4, TIMEOUT4} !== 2'b10) begin
        bad++;
        $display("FAIL timeout_hold2 cycle %0d got vld=%0b to=%0b want 1/0", c, GNT_VLD4, TIMEOUT4);
      end
    end
    DONE4 = 1'b1;  // coincides with the limit
    tick();
    DONE4 = 1'b0; REQ4 = '0;
    total++;
    if ({GNT_VLD4, TIMEOUT4} !== 2'b00) begin
      bad++;
      $display("FAIL done_at_limit got vld=%0b to=%0b want 0/0", GNT_VLD4, TIMEOUT4);
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    REQ = 16'h0200;  // PTR=5 here
    tick();
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd9}) begin
      bad++;
      $display("FAIL mid_grant_setup got vld=%0b idx=%0d want 1/9", GNT_VLD, GNT_IDX);
    end
    RST_N = 1'b0;
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX, TIMEOUT} !== 6'b0) begin
      bad++;
      $display("FAIL mid_grant_reset got vld=%0b idx=%0d to=%0b want 0/0/0", GNT_VLD, GNT_IDX, TIMEOUT);
    end
    RST_N = 1'b1; REQ = 16'h0201;
    tick();
    total++;
    if ({GNT_VLD, GNT_IDX} !== {1'b1, 4'd0}) begin
      bad++;
      $display("FAIL post_reset_first got vld=%0b idx=%0d want 1/0", GNT_VLD, GNT_IDX);
    end
    REQ = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_implicit_release();
    test_timeout();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
